// File: rtl/sounder_pn_gen.sv
// rtl/sounder_pn_gen.sv - Sounder PN chip generator: serial-configured Galois LFSR driving DAC chips
//
// Ports:
//   clk_i        single master clock
//   rst_n_i      synchronous active-low reset
//   ena_i        transmit enable from master control
//   saddr_i      serial register address
//   sdata_i      serial register data
//   s_strobe_i   one-cycle serial write strobe
//   strobe_o     chip strobe to the DAC interface
//   tx_i_o       two's-complement I chip value (+A / -A)
//   tx_q_o       Q value, always zero
//   seq_start_o  marks the strobe carrying chip 0 of each period
module sounder_pn_gen #(
  parameter logic [6:0] ADDR_CTRL = 7'd64,
  parameter logic [6:0] ADDR_POLY = 7'd65,
  parameter logic [6:0] ADDR_LEN  = 7'd66,
  parameter logic [6:0] ADDR_AMPL = 7'd67
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ena_i,
  input  logic [6:0]  saddr_i,
  input  logic [31:0] sdata_i,
  input  logic        s_strobe_i,
  output logic        strobe_o,
  output logic [13:0] tx_i_o,
  output logic [13:0] tx_q_o,
  output logic        seq_start_o
);

  // configuration registers
  logic        ctrl_run;
  logic [7:0]  div_d;
  logic [15:0] mask;
  logic [15:0] len;
  logic [12:0] ampl;

  // sequence state
  logic [15:0] lfsr;
  logic [15:0] chip_cnt;
  logic [7:0]  div_cnt;

  // chip captured at the chip event, presented on the outputs one edge later
  logic        chip_pend;
  logic        chip_bit;
  logic        chip_first;

  logic        wr_ctrl;
  logic        wr_poly;
  logic        wr_len;
  logic        wr_ampl;
  logic        running;
  logic        restart;
  logic        chip_evt;
  logic [13:0] amp_pos;
  logic [13:0] amp_neg;
  logic        unused_sdata;

  assign wr_ctrl = s_strobe_i && (saddr_i == ADDR_CTRL);
  assign wr_poly = s_strobe_i && (saddr_i == ADDR_POLY);
  assign wr_len  = s_strobe_i && (saddr_i == ADDR_LEN);
  assign wr_ampl = s_strobe_i && (saddr_i == ADDR_AMPL);

  assign running = ctrl_run && ena_i;

  // Any write that changes the sequence shape, or not running, parks the
  // generator at its start point so the next run always begins at chip 0.
  assign restart  = wr_ctrl || wr_poly || wr_len || !running;
  assign chip_evt = !restart && (div_cnt == 8'd0);

  assign amp_pos = {1'b0, ampl};
  assign amp_neg = 14'd0 - amp_pos;

  assign tx_q_o = 14'd0;

  assign unused_sdata = ^{sdata_i[31:16], sdata_i[7:1]};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ctrl_run    <= 1'b0;
      div_d       <= 8'd0;
      mask        <= 16'hB400;
      len         <= 16'd65534;
      ampl        <= 13'd4096;
      lfsr        <= 16'h0001;
      chip_cnt    <= 16'd0;
      div_cnt     <= 8'd0;
      chip_pend   <= 1'b0;
      chip_bit    <= 1'b0;
      chip_first  <= 1'b0;
      strobe_o    <= 1'b0;
      tx_i_o      <= 14'd0;
      seq_start_o <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_run <= sdata_i[0];
        div_d    <= sdata_i[15:8];
      end
      if (wr_poly) mask <= sdata_i[15:0];
      if (wr_len)  len  <= sdata_i[15:0];
      if (wr_ampl) ampl <= sdata_i[12:0];

      if (restart) begin
        lfsr     <= 16'h0001;
        chip_cnt <= 16'd0;
        div_cnt  <= 8'd0;
      end else begin
        div_cnt <= (div_cnt == div_d) ? 8'd0 : div_cnt + 8'd1;
        if (div_cnt == 8'd0) begin
          // the last chip of the period reloads the seed instead of shifting
          if (chip_cnt == len) begin
            chip_cnt <= 16'd0;
            lfsr     <= 16'h0001;
          end else begin
            chip_cnt <= chip_cnt + 16'd1;
            lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? mask : 16'h0000);
          end
        end
      end

      chip_pend  <= chip_evt;
      chip_bit   <= lfsr[0];
      chip_first <= (chip_cnt == 16'd0);

      if (!running) begin
        strobe_o    <= 1'b0;
        tx_i_o      <= 14'd0;
        seq_start_o <= 1'b0;
      end else if (chip_pend) begin
        // amplitude is read here so an amplitude write takes effect on the next chip
        strobe_o    <= 1'b1;
        tx_i_o      <= chip_bit ? amp_pos : amp_neg;
        seq_start_o <= chip_first;
      end else begin
        strobe_o    <= 1'b0;
        seq_start_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sounder_pn_gen.sv
// tb/tb_sounder_pn_gen.sv - Self-checking bench for sounder_pn_gen
module tb_sounder_pn_gen;

  localparam logic [6:0] A_CTRL = 7'd64;
  localparam logic [6:0] A_POLY = 7'd65;
  localparam logic [6:0] A_LEN  = 7'd66;
  localparam logic [6:0] A_AMPL = 7'd67;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [6:0]  saddr;
  logic [31:0] sdata;
  logic        s_strobe;
  logic        strobe;
  logic [13:0] tx_i;
  logic [13:0] tx_q;
  logic        seq_start;

  int errors = 0;
  int checks = 0;

  bit          ref_bits[$];
  logic        c_stb[$];
  logic [13:0] c_tx[$];
  logic        c_seq[$];

  sounder_pn_gen dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .ena_i       (ena),
    .saddr_i     (saddr),
    .sdata_i     (sdata),
    .s_strobe_i  (s_strobe),
    .strobe_o    (strobe),
    .tx_i_o      (tx_i),
    .tx_q_o      (tx_q),
    .seq_start_o (seq_start)
  );

  always #5 clk = ~clk;

  // one period of chip bits, straight from the LFSR rule with seed 1
  task automatic build_ref(input logic [15:0] m, input int l);
    logic [15:0] s;
    ref_bits.delete();
    s = 16'h0001;
    for (int i = 0; i <= l; i++) begin
      ref_bits.push_back(s[0]);
      s = (s >> 1) ^ (s[0] ? m : 16'h0000);
    end
  endtask

  function automatic logic [13:0] exp_tx(input bit b, input int a);
    logic [13:0] p;
    p = 14'(a);
    return b ? p : (14'd0 - p);
  endfunction

  // caller is at a negedge; returns at the following negedge
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    saddr = a;
    sdata = d;
    s_strobe = 1'b1;
    @(negedge clk);
    s_strobe = 1'b0;
    saddr = 7'd0;
    sdata = 32'd0;
  endtask

  task automatic collect(input int n, input bit append);
    if (!append) begin
      c_stb.delete();
      c_tx.delete();
      c_seq.delete();
    end
    repeat (n) begin
      @(negedge clk);
      c_stb.push_back(strobe);
      c_tx.push_back(tx_i);
      c_seq.push_back(seq_start);
    end
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0; ena = 1'b0; saddr = 7'd0; sdata = 32'd0; s_strobe = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0h expected 0", strobe); end
    checks++; if (tx_i !== 14'd0) begin errors++; $display("FAIL reset_tx_i: got %0h expected 0", tx_i); end
    checks++; if (tx_q !== 14'd0) begin errors++; $display("FAIL reset_tx_q: got %0h expected 0", tx_q); end
    checks++; if (seq_start !== 1'b0) begin errors++; $display("FAIL reset_seq: got %0h expected 0", seq_start); end
    rst_n = 1'b1;
    ena = 1'b1;
    collect(6, 0);
    bad = 0;
    foreach (c_stb[i]) if (c_stb[i] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_run_off: got %0d strobes expected 0", bad); end
  endtask

  task automatic test_basic;
    int k;
    build_ref(16'h0006, 6);
    wr(A_AMPL, 32'd100);
    wr(A_POLY, 32'h0006);
    wr(A_LEN, 32'd6);
    wr(A_CTRL, 32'h0001);
    collect(23, 0);
    checks++; if (c_stb[0] !== 1'b0) begin errors++; $display("FAIL basic_latency: got strobe %0h at cycle 1 expected 0", c_stb[0]); end
    k = 0;
    foreach (c_stb[i]) if (c_stb[i]) begin
      checks++; if (i + 1 != 2 + k) begin errors++; $display("FAIL basic_time: strobe %0d at cycle %0d expected %0d", k, i + 1, 2 + k); end
      checks++; if (c_tx[i] !== exp_tx(ref_bits[k % 7], 100)) begin errors++; $display("FAIL basic_tx: chip %0d got %0h expected %0h", k, c_tx[i], exp_tx(ref_bits[k % 7], 100)); end
      checks++; if (c_seq[i] !== (k % 7 == 0)) begin errors++; $display("FAIL basic_seq: chip %0d got %0h expected %0h", k, c_seq[i], (k % 7 == 0)); end
      k++;
    end
    checks++; if (k != 22) begin errors++; $display("FAIL basic_count: got %0d expected 22", k); end
    checks++; if (tx_q !== 14'd0) begin errors++; $display("FAIL basic_tx_q: got %0h expected 0", tx_q); end
  endtask

  task automatic test_ena_drop;
    int k;
    int bad;
    collect(3, 0);
    ena = 1'b0;
    collect(5, 0);
    checks++; if ({c_stb[0], c_tx[0], c_seq[0]} !== 16'd0) begin errors++; $display("FAIL ena_off_first: got stb=%0h tx=%0h seq=%0h expected 0", c_stb[0], c_tx[0], c_seq[0]); end
    bad = 0;
    foreach (c_stb[i]) if ({c_stb[i], c_tx[i], c_seq[i]} !== 16'd0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ena_off_hold: got %0d nonzero cycles expected 0", bad); end
    ena = 1'b1;
    collect(16, 0);
    checks++; if (c_stb[0] !== 1'b0) begin errors++; $display("FAIL ena_latency: got strobe %0h at cycle 1 expected 0", c_stb[0]); end
    checks++; if (c_stb[1] !== 1'b1 || c_tx[1] !== 14'd100 || c_seq[1] !== 1'b1) begin errors++; $display("FAIL ena_first_chip: got stb=%0h tx=%0h seq=%0h expected 1/64/1", c_stb[1], c_tx[1], c_seq[1]); end
    k = 0;
    foreach (c_stb[i]) if (c_stb[i]) begin
      checks++; if (c_tx[i] !== exp_tx(ref_bits[k % 7], 100) || c_seq[i] !== (k % 7 == 0)) begin errors++; $display("FAIL ena_seq: chip %0d got tx=%0h seq=%0h expected tx=%0h", k, c_tx[i], c_seq[i], exp_tx(ref_bits[k % 7], 100)); end
      k++;
    end
    checks++; if (k != 15) begin errors++; $display("FAIL ena_count: got %0d expected 15", k); end
  endtask

  task automatic test_ampl_change;
    int k;
    logic [13:0] ov;
    logic [13:0] nv;
    bit bad;
    wr(A_CTRL, 32'h0001);
    collect(5, 0);
    saddr = A_AMPL; sdata = 32'd8191; s_strobe = 1'b1;
    collect(1, 1);
    s_strobe = 1'b0; saddr = 7'd0; sdata = 32'd0;
    collect(24, 1);
    k = 0;
    foreach (c_stb[i]) if (c_stb[i]) begin
      ov = exp_tx(ref_bits[k % 7], 100);
      nv = exp_tx(ref_bits[k % 7], 8191);
      if (k < 4) bad = (c_tx[i] !== ov);
      else if (k > 4) bad = (c_tx[i] !== nv);
      else bad = (c_tx[i] !== ov) && (c_tx[i] !== nv);
      checks++; if (bad) begin errors++; $display("FAIL ampl_tx: chip %0d got %0h expected %0h", k, c_tx[i], (k < 4) ? ov : nv); end
      checks++; if (c_seq[i] !== (k % 7 == 0) || i + 1 != 2 + k) begin errors++; $display("FAIL ampl_seq: chip %0d at cycle %0d got seq %0h", k, i + 1, c_seq[i]); end
      k++;
    end
    checks++; if (k != 29) begin errors++; $display("FAIL ampl_count: got %0d expected 29", k); end
  endtask

  task automatic test_divider;
    int k;
    int bad;
    wr(A_AMPL, 32'd100);
    wr(A_CTRL, 32'h0301);
    collect(40, 0);
    k = 0;
    bad = 0;
    foreach (c_stb[i]) begin
      if (c_stb[i]) begin
        checks++; if (i + 1 != 2 + 4 * k) begin errors++; $display("FAIL div_time: strobe %0d at cycle %0d expected %0d", k, i + 1, 2 + 4 * k); end
        checks++; if (c_tx[i] !== exp_tx(ref_bits[k % 7], 100) || c_seq[i] !== (k % 7 == 0)) begin errors++; $display("FAIL div_tx: chip %0d got tx=%0h seq=%0h expected tx=%0h", k, c_tx[i], c_seq[i], exp_tx(ref_bits[k % 7], 100)); end
        k++;
      end else if (k > 0 && (c_tx[i] !== c_tx[i - 1] || c_seq[i] !== 1'b0)) begin
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL div_hold: got %0d bad idle cycles expected 0", bad); end
    checks++; if (k != 10) begin errors++; $display("FAIL div_count: got %0d expected 10", k); end
    wr(A_CTRL, 32'hFF01);
    collect(771, 0);
    k = 0;
    foreach (c_stb[i]) if (c_stb[i]) begin
      checks++; if (i + 1 != 2 + 256 * k) begin errors++; $display("FAIL div255_time: strobe %0d at cycle %0d expected %0d", k, i + 1, 2 + 256 * k); end
      k++;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL div255_count: got %0d expected 4", k); end
  endtask

  task automatic test_mask_zero;
    int k;
    build_ref(16'h0000, 5);
    wr(A_POLY, 32'h0000);
    wr(A_LEN, 32'd5);
    wr(A_CTRL, 32'h0001);
    collect(14, 0);
    k = 0;
    foreach (c_stb[i]) if (c_stb[i]) begin
      checks++; if (c_tx[i] !== exp_tx(ref_bits[k % 6], 100) || c_seq[i] !== (k % 6 == 0)) begin errors++; $display("FAIL mask0_tx: chip %0d got tx=%0h seq=%0h expected tx=%0h", k, c_tx[i], c_seq[i], exp_tx(ref_bits[k % 6], 100)); end
      k++;
    end
    checks++; if (k != 13) begin errors++; $display("FAIL mask0_count: got %0d expected 13", k); end
  endtask

  task automatic test_random;
    logic [15:0] m;
    int l;
    int a;
    int d;
    int n;
    int k;
    int p;
    logic [31:0] junk;
    for (int it = 0; it < 4; it++) begin
      m = 16'($urandom);
      l = $urandom_range(1, 20);
      a = $urandom_range(0, 8191);
      d = $urandom_range(0, 3);
      p = l + 1;
      build_ref(m, l);
      junk = $urandom;
      wr(A_AMPL, {junk[31:13], 13'(a)});
      wr(A_POLY, {junk[31:16], m});
      wr(A_LEN, {junk[31:16], 16'(l)});
      wr(A_CTRL, {junk[31:16], 8'(d), junk[7:1], 1'b1});
      n = 1 + 2 * p * (d + 1);
      collect(n, 0);
      k = 0;
      foreach (c_stb[i]) if (c_stb[i]) begin
        checks++; if (i + 1 != 2 + k * (d + 1)) begin errors++; $display("FAIL rand_time: it %0d strobe %0d at cycle %0d expected %0d", it, k, i + 1, 2 + k * (d + 1)); end
        checks++; if (c_tx[i] !== exp_tx(ref_bits[k % p], a) || c_seq[i] !== (k % p == 0)) begin errors++; $display("FAIL rand_tx: it %0d chip %0d got tx=%0h seq=%0h expected tx=%0h", it, k, c_tx[i], c_seq[i], exp_tx(ref_bits[k % p], a)); end
        k++;
      end
      checks++; if (k != (n - 2) / (d + 1) + 1) begin errors++; $display("FAIL rand_count: it %0d got %0d expected %0d", it, k, (n - 2) / (d + 1) + 1); end
    end
  endtask

  task automatic test_reset_midseq;
    int bad;
    wr(A_CTRL, 32'h0001);
    collect(4, 0);
    rst_n = 1'b0;
    saddr = A_CTRL; sdata = 32'h0301; s_strobe = 1'b1;
    @(negedge clk);
    checks++; if ({strobe, tx_i, tx_q, seq_start} !== 30'd0) begin errors++; $display("FAIL rst_mid_out: got stb=%0h tx_i=%0h tx_q=%0h seq=%0h expected 0", strobe, tx_i, tx_q, seq_start); end
    s_strobe = 1'b0; saddr = 7'd0; sdata = 32'd0;
    rst_n = 1'b1;
    collect(12, 0);
    bad = 0;
    foreach (c_stb[i]) if (c_stb[i] !== 1'b0 || c_tx[i] !== 14'd0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_run: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_defaults;
    int k;
    int cyc;
    int first;
    int ones;
    int tx_bad;
    int seq_bad;
    k = 0; cyc = 0; first = 0; ones = 0; tx_bad = 0; seq_bad = 0;
    build_ref(16'hB400, 65534);
    wr(A_CTRL, 32'h0001);
    while (k < 65536 && cyc < 65700) begin
      @(negedge clk);
      cyc++;
      if (strobe) begin
        if (k == 0) first = cyc;
        if (tx_i !== exp_tx(ref_bits[k % 65535], 4096)) tx_bad++;
        if (seq_start !== (k % 65535 == 0)) seq_bad++;
        if (k < 65535 && tx_i === 14'd4096) ones++;
        k++;
      end
    end
    checks++; if (first != 2) begin errors++; $display("FAIL dflt_latency: got %0d expected 2", first); end
    checks++; if (k != 65536) begin errors++; $display("FAIL dflt_count: got %0d expected 65536", k); end
    checks++; if (tx_bad != 0) begin errors++; $display("FAIL dflt_tx: got %0d wrong chips expected 0", tx_bad); end
    checks++; if (seq_bad != 0) begin errors++; $display("FAIL dflt_seq: got %0d wrong seq_start expected 0", seq_bad); end
    checks++; if (ones != 32768) begin errors++; $display("FAIL dflt_ones: got %0d expected 32768", ones); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ena_drop();
    test_ampl_change();
    test_divider();
    test_mask_zero();
    test_random();
    test_reset_midseq();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sounder_pn_gen.md
SOUNDER_PN_GEN -- requirements
Module: sounder_pn_gen

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 7'd64, serial address of the control register (bit0 run, bits[15:8] divider D).
REQ-002 SHALL have parameter ADDR_POLY, default 7'd65, serial address of the LFSR feedback mask (bits[15:0]).
REQ-003 SHALL have parameter ADDR_LEN, default 7'd66, serial address of the sequence length register L (bits[15:0]; period = L+1 chips).
REQ-004 SHALL have parameter ADDR_AMPL, default 7'd67, serial address of the chip amplitude A (bits[12:0]).
REQ-005 SHALL have port clk_i, input, 1 bit: single clock (64 MHz master clock).
REQ-006 SHALL have port rst_n_i, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port ena_i, input, 1 bit: transmit enable from master control.
REQ-008 SHALL have port saddr_i, input, 7 bits: serial register address.
REQ-009 SHALL have port sdata_i, input, 32 bits: serial register data.
REQ-010 SHALL have port s_strobe_i, input, 1 bit: one-cycle serial write strobe.
REQ-011 SHALL have port strobe_o, output, 1 bit: chip strobe, feeds the DAC interface strobe input.
REQ-012 SHALL have port tx_i_o, output, 14 bits: two's-complement I chip value.
REQ-013 SHALL have port tx_q_o, output, 14 bits: Q value, constant zero.
REQ-014 SHALL have port seq_start_o, output, 1 bit: high coincident with the strobe of chip 0 of each period.

Function
REQ-015 SHALL capture a register on any clk_i edge with s_strobe_i=1 and saddr_i equal to its address; all other addresses are ignored.
REQ-016 SHALL define running = ctrl.run AND ena_i.
REQ-017 SHALL, on any write to ADDR_CTRL, ADDR_POLY or ADDR_LEN, and whenever running is 0, hold lfsr=16'h0001, chip counter=0, divider counter=0 (restart).
REQ-018 SHALL, while running, count the divider 0..D and wrap; a chip event occurs in each cycle the divider equals 0.
REQ-019 SHALL, at each chip event, advance a right-shifting Galois LFSR: next = (lfsr>>1) XOR (lfsr[0] ? mask : 0); chip bit = lfsr[0] before the shift.
REQ-020 SHALL, at each chip event, increment the chip counter; when it equals L it SHALL wrap to 0 and reload lfsr=16'h0001 instead of shifting.
REQ-021 SHALL register all outputs: one cycle after a chip event, strobe_o=1, tx_i_o=+A if chip bit 1 else -A (sign-extended to 14 bits), seq_start_o=1 iff chip counter was 0; otherwise strobe_o=0 and seq_start_o=0.
REQ-022 SHALL hold tx_i_o at its last chip value between strobes while running; SHALL drive tx_i_o=0, strobe_o=0, seq_start_o=0 in the cycle after running falls.
REQ-023 SHALL drive tx_q_o=14'd0 at all times.
REQ-024 SHALL produce the first strobe_o exactly 2 cycles after the clk_i edge that makes running 1 (load edge, then output edge), carrying chip 0 with seq_start_o=1.
REQ-025 SHALL apply an ADDR_AMPL write from the next chip onward without restart.
REQ-026 SHALL, with mask=0, output chip 1 then all-zero bits until the period wraps (no lock-up protection required).
REQ-027 SHALL give a D=0 configuration a strobe every cycle; D=255 gives one strobe per 256 cycles.

Reset
REQ-028 SHALL, on rst_n_i=0 at a clk_i edge, set ctrl=0 (run=0, D=0), mask=16'hB400, L=16'd65534, A=13'd4096, lfsr=16'h0001, counters=0, strobe_o=0, seq_start_o=0, tx_i_o=0, tx_q_o=0.
REQ-029 SHALL give reset priority over simultaneous serial writes and over running.

Verification
REQ-030 Reset, ena_i=1, write POLY=16'h0006, LEN=6, AMPL=100, CTRL=16'h0001 -> strobe every cycle, tx_i_o sequence +100,-100,+100,+100,+100,-100,-100 repeating, seq_start_o every 7th strobe.
REQ-031 Same config with CTRL=16'h0301 -> strobe_o high 1 cycle in 4, same chip sequence, tx_i_o held between strobes.
REQ-032 Running, drop ena_i for 5 cycles then restore -> outputs zero next cycle; first strobe 2 cycles after restore carries chip 0 (+100, seq_start_o=1).
REQ-033 Write AMPL=8191 mid-period -> subsequent chips +8191 (14'h1FFF) / -8191 (14'h2001), no seq_start_o glitch, sequence unbroken.
REQ-034 Assert rst_n_i mid-sequence concurrent with a CTRL write -> all outputs 0 next cycle, registers at reset defaults, run=0.
REQ-035 Defaults with CTRL=16'h0001 -> seq_start_o period 65535 strobes; chip count of 1s equals 32768 per period.
